// File: rtl/load_response_scatter_unit_pkg.sv
// rtl/load_response_scatter_unit_pkg.sv - shared types, sizes and helpers for the load response scatter unit
package ldst_pkg;

  localparam int LINE_BYTES = 32;
  localparam int LINE_BITS  = LINE_BYTES * 8;
  localparam int N          = LINE_BYTES / 4;
  localparam int O          = $clog2(LINE_BYTES);
  localparam int NUM_TAGS   = 4;
  localparam int TAG_W      = $clog2(NUM_TAGS);
  localparam int BIT_W      = $clog2(N);

  typedef enum logic [1:0] {
    SIZE_1B = 2'b00,
    SIZE_2B = 2'b01,
    SIZE_4B = 2'b10,
    SIZE_8B = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_SCATTER = 1'b1
  } state_e;

  typedef struct packed {
    logic [3:0]     block_id;
    logic [9:0]     base_tid;
    logic [N-1:0]   tid_bitmap;
    size_e          size;
    logic [6:0]     ld_dest_reg;
    logic [N*O-1:0] address_map;
  } tag_entry_t;

  function automatic logic [3:0] size_to_bytes(size_e s);
    return 4'd1 << s;
  endfunction

  function automatic logic [BIT_W-1:0] lowest_set_bit(logic [N-1:0] v);
    logic [BIT_W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = BIT_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/load_response_scatter_unit_if.sv
// rtl/load_response_scatter_unit_if.sv - command, memory and writeback buses of the scatter unit
interface load_response_scatter_unit_if;
  import ldst_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic [3:0]           req_block_id;
  logic [9:0]           req_base_tid;
  logic [N-1:0]         req_tid_bitmap;
  logic                 req_write_enable;
  logic [LINE_BITS-1:0] req_write_data;
  logic [LINE_BYTES-1:0] req_write_mask;
  logic [63:0]          req_address;
  logic [1:0]           req_size;
  logic [6:0]           req_ld_dest_reg;
  logic [N*O-1:0]       req_address_map;

  logic                 mem_req_valid;
  logic                 mem_req_ready;
  logic                 mem_req_write_enable;
  logic [LINE_BITS-1:0] mem_req_write_data;
  logic [LINE_BYTES-1:0] mem_req_write_mask;
  logic [63:0]          mem_req_address;
  logic [TAG_W-1:0]     mem_req_tag;

  logic                 mem_rsp_valid;
  logic                 mem_rsp_ready;
  logic [TAG_W-1:0]     mem_rsp_tag;
  logic [LINE_BITS-1:0] mem_rsp_data;

  logic                 wb_valid;
  logic                 wb_ready;
  logic [3:0]           wb_block_id;
  logic [9:0]           wb_tid;
  logic [6:0]           wb_ld_dest_reg;
  logic [63:0]          wb_data;

  logic [TAG_W:0]       outstanding_count;
  logic                 err_unexpected_rsp;

  modport slave (
    input  req_valid, req_block_id, req_base_tid, req_tid_bitmap, req_write_enable,
           req_write_data, req_write_mask, req_address, req_size, req_ld_dest_reg, req_address_map,
           mem_req_ready, mem_rsp_valid, mem_rsp_tag, mem_rsp_data, wb_ready,
    output req_ready, mem_req_valid, mem_req_write_enable, mem_req_write_data, mem_req_write_mask,
           mem_req_address, mem_req_tag, mem_rsp_ready, wb_valid, wb_block_id, wb_tid,
           wb_ld_dest_reg, wb_data, outstanding_count, err_unexpected_rsp
  );

  modport master (
    output req_valid, req_block_id, req_base_tid, req_tid_bitmap, req_write_enable,
           req_write_data, req_write_mask, req_address, req_size, req_ld_dest_reg, req_address_map,
           mem_req_ready, mem_rsp_valid, mem_rsp_tag, mem_rsp_data, wb_ready,
    input  req_ready, mem_req_valid, mem_req_write_enable, mem_req_write_data, mem_req_write_mask,
           mem_req_address, mem_req_tag, mem_rsp_ready, wb_valid, wb_block_id, wb_tid,
           wb_ld_dest_reg, wb_data, outstanding_count, err_unexpected_rsp
  );

endinterface

// File: rtl/load_response_scatter_unit_tag_table.sv
// rtl/load_response_scatter_unit_tag_table.sv - outstanding-load metadata with lowest-free allocation
module ldst_tag_table
  import ldst_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_alloc,
  input  tag_entry_t          i_alloc_entry,
  output logic [TAG_W-1:0]    o_alloc_tag,
  output logic                o_free_exists,
  input  logic                i_free,
  input  logic [TAG_W-1:0]    i_free_tag,
  input  logic [TAG_W-1:0]    i_lookup_tag,
  output tag_entry_t          o_lookup_entry,
  output logic [NUM_TAGS-1:0] o_valid,
  output logic [TAG_W:0]      o_count
);

  logic [NUM_TAGS-1:0] r_valid;
  tag_entry_t          r_entries [NUM_TAGS];

  // Allocation looks only at the registered valid vector, so a tag freed this cycle is reusable next cycle.
  always_comb begin
    o_alloc_tag   = '0;
    o_free_exists = 1'b0;
    o_count       = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        o_alloc_tag   = TAG_W'(i);
        o_free_exists = 1'b1;
      end
    end
    for (int i = 0; i < NUM_TAGS; i++) begin
      o_count = o_count + (TAG_W + 1)'(r_valid[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      if (i_free) r_valid[i_free_tag] <= 1'b0;
      if (i_alloc) r_valid[o_alloc_tag] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_alloc) r_entries[o_alloc_tag] <= i_alloc_entry;
  end

  assign o_lookup_entry = r_entries[i_lookup_tag];
  assign o_valid        = r_valid;

endmodule

// File: rtl/load_response_scatter_unit.sv
// rtl/load_response_scatter_unit.sv - tags coalesced loads and scatters each returned line into per-thread writebacks
module load_response_scatter_unit
  import ldst_pkg::*;
(
  input logic clk,
  input logic rst,
  load_response_scatter_unit_if.slave bus
);

  state_e               r_state, w_state_next;
  tag_entry_t           r_entry;
  logic [LINE_BITS-1:0] r_line;
  logic [TAG_W-1:0]     r_tag;
  logic                 r_err;

  tag_entry_t           w_new_entry, w_lookup_entry;
  logic [NUM_TAGS-1:0]  w_valid_vec;
  logic [TAG_W-1:0]     w_alloc_tag;
  logic                 w_free_exists, w_can_issue, w_alloc, w_free, w_latch, w_set_err, w_wb_hs;
  logic [N-1:0]         w_bitmap_next;
  logic [BIT_W-1:0]     w_bit;
  logic [O-1:0]         w_map_off, w_off;
  logic [63:0]          w_shifted, w_data;

  assign w_can_issue            = bus.req_write_enable || w_free_exists;
  assign bus.mem_req_valid      = bus.req_valid && w_can_issue;
  assign bus.req_ready          = bus.mem_req_ready && w_can_issue;
  assign w_alloc                = bus.req_valid && bus.req_ready && !bus.req_write_enable;
  assign bus.mem_req_tag        = bus.req_write_enable ? '0 : w_alloc_tag;
  assign bus.mem_req_write_enable = bus.req_write_enable;
  assign bus.mem_req_write_data = bus.req_write_data;
  assign bus.mem_req_write_mask = bus.req_write_mask;
  assign bus.mem_req_address    = bus.req_address;

  assign w_new_entry = '{block_id:    bus.req_block_id,
                         base_tid:    bus.req_base_tid,
                         tid_bitmap:  bus.req_tid_bitmap,
                         size:        size_e'(bus.req_size),
                         ld_dest_reg: bus.req_ld_dest_reg,
                         address_map: bus.req_address_map};

  ldst_tag_table u_tag_table (
    .clk            (clk),
    .rst            (rst),
    .i_alloc        (w_alloc),
    .i_alloc_entry  (w_new_entry),
    .o_alloc_tag    (w_alloc_tag),
    .o_free_exists  (w_free_exists),
    .i_free         (w_free),
    .i_free_tag     (r_tag),
    .i_lookup_tag   (bus.mem_rsp_tag),
    .o_lookup_entry (w_lookup_entry),
    .o_valid        (w_valid_vec),
    .o_count        (bus.outstanding_count)
  );

  // Lane offset is aligned down to the access size so an access never straddles its natural boundary.
  assign w_bit     = lowest_set_bit(r_entry.tid_bitmap);
  assign w_map_off = r_entry.address_map[int'(w_bit) * O +: O];
  assign w_off     = w_map_off & ~(O'(size_to_bytes(r_entry.size)) - O'(1));
  assign w_shifted = 64'(r_line >> {w_off, 3'b000});

  always_comb begin
    w_data = '0;
    case (r_entry.size)
      SIZE_1B: w_data = {56'd0, w_shifted[7:0]};
      SIZE_2B: w_data = {48'd0, w_shifted[15:0]};
      SIZE_4B: w_data = {32'd0, w_shifted[31:0]};
      SIZE_8B: w_data = w_shifted;
      default: w_data = '0;
    endcase
  end

  assign bus.wb_block_id        = r_entry.block_id;
  assign bus.wb_tid             = r_entry.base_tid + 10'(w_bit);
  assign bus.wb_ld_dest_reg     = r_entry.ld_dest_reg;
  assign bus.wb_data            = w_data;
  assign bus.err_unexpected_rsp = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next      = r_state;
    w_free            = 1'b0;
    w_latch           = 1'b0;
    w_set_err         = 1'b0;
    bus.mem_rsp_ready = 1'b0;
    bus.wb_valid      = 1'b0;
    w_bitmap_next     = r_entry.tid_bitmap & ~(N'(1) << w_bit);
    case (r_state)
      ST_IDLE: begin
        bus.mem_rsp_ready = 1'b1;
        if (bus.mem_rsp_valid) begin
          if (w_valid_vec[bus.mem_rsp_tag]) begin
            w_latch      = 1'b1;
            w_state_next = ST_SCATTER;
          end else begin
            w_set_err = 1'b1;
          end
        end
      end
      ST_SCATTER: begin
        bus.wb_valid = |r_entry.tid_bitmap;
        if (!bus.wb_valid || (bus.wb_ready && w_bitmap_next == '0)) begin
          w_free       = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    w_wb_hs = bus.wb_valid && bus.wb_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_entry <= '0;
      r_line  <= '0;
      r_tag   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_latch) begin
        r_entry <= w_lookup_entry;
        r_line  <= bus.mem_rsp_data;
        r_tag   <= bus.mem_rsp_tag;
      end else if (w_wb_hs) begin
        r_entry.tid_bitmap <= w_bitmap_next;
      end
      if (w_set_err) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_load_response_scatter_unit.sv
// tb/tb_load_response_scatter_unit.sv - directed self-checking bench for load_response_scatter_unit
module tb_load_response_scatter_unit;
  import ldst_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   n_wb;
  logic [LINE_BITS-1:0] line;

  load_response_scatter_unit_if bus();

  load_response_scatter_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_step();
    if (bus.wb_valid && bus.wb_ready) n_wb++;
    tick();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_load(input logic [9:0] base, input logic [N-1:0] bm, input logic [1:0] sz,
                          input logic [N*O-1:0] amap);
    bus.req_valid        = 1'b1;
    bus.req_write_enable = 1'b0;
    bus.req_block_id     = 4'h9;
    bus.req_base_tid     = base;
    bus.req_tid_bitmap   = bm;
    bus.req_size         = sz;
    bus.req_ld_dest_reg  = 7'h2A;
    bus.req_address_map  = amap;
    bus.req_address      = 64'h1000;
  endtask

  task automatic send_rsp(input logic [TAG_W-1:0] tag);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_tag   = tag;
    bus.mem_rsp_data  = line;
    tick();
    bus.mem_rsp_valid = 1'b0;
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    n_wb     = 0;
    for (int k = 0; k < LINE_BYTES; k++) line[k*8 +: 8] = 8'(k);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_block_id = '0;
    bus.req_base_tid = '0;
    bus.req_tid_bitmap = '0;
    bus.req_write_enable = 1'b0;
    bus.req_write_data = '0;
    bus.req_write_mask = '0;
    bus.req_address = '0;
    bus.req_size = '0;
    bus.req_ld_dest_reg = '0;
    bus.req_address_map = '0;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_tag = '0;
    bus.mem_rsp_data = '0;
    bus.wb_ready = 1'b1;
    tick();
    tick();
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_err", 64'(bus.err_unexpected_rsp), 64'd0);
    chk("rst_count", 64'(bus.outstanding_count), 64'd0);
    chk("rst_rsp_ready", 64'(bus.mem_rsp_ready), 64'd1);
    rst = 1'b0;
    tick();

    // Basic 4-byte scatter of two threads
    set_load(10'h040, 8'h05, 2'b10, 40'd8 << 10);
    #1;
    chk("t1_mem_req_valid", 64'(bus.mem_req_valid), 64'd1);
    chk("t1_req_ready", 64'(bus.req_ready), 64'd1);
    chk("t1_tag", 64'(bus.mem_req_tag), 64'd0);
    tick();
    bus.req_valid = 1'b0;
    #1;
    chk("t1_count", 64'(bus.outstanding_count), 64'd1);
    send_rsp(2'd0);
    chk("t1_wb0_valid", 64'(bus.wb_valid), 64'd1);
    chk("t1_wb0_tid", 64'(bus.wb_tid), 64'h040);
    chk("t1_wb0_data", bus.wb_data, 64'h03020100);
    chk("t1_wb0_blk", 64'(bus.wb_block_id), 64'h9);
    chk("t1_wb0_dst", 64'(bus.wb_ld_dest_reg), 64'h2A);
    chk("t1_rsp_ready_busy", 64'(bus.mem_rsp_ready), 64'd0);
    tick();
    chk("t1_wb1_valid", 64'(bus.wb_valid), 64'd1);
    chk("t1_wb1_tid", 64'(bus.wb_tid), 64'h042);
    chk("t1_wb1_data", bus.wb_data, 64'h0B0A0908);
    tick();
    chk("t1_done_valid", 64'(bus.wb_valid), 64'd0);
    chk("t1_done_count", 64'(bus.outstanding_count), 64'd0);
    chk("t1_rsp_ready_idle", 64'(bus.mem_rsp_ready), 64'd1);

    // Fill all tags, then a load stalls while a store passes
    for (int i = 0; i < NUM_TAGS; i++) begin
      set_load(10'h100 + 10'(i), 8'h01, 2'b00, 40'd5);
      #1;
      chk($sformatf("t2_tag%0d", i), 64'(bus.mem_req_tag), 64'(i));
      tick();
    end
    #1;
    chk("t2_full_count", 64'(bus.outstanding_count), 64'd4);
    chk("t2_full_ready", 64'(bus.req_ready), 64'd0);
    chk("t2_full_valid", 64'(bus.mem_req_valid), 64'd0);
    bus.req_write_enable = 1'b1;
    #1;
    chk("t2_store_ready", 64'(bus.req_ready), 64'd1);
    chk("t2_store_valid", 64'(bus.mem_req_valid), 64'd1);
    chk("t2_store_tag", 64'(bus.mem_req_tag), 64'd0);
    tick();
    bus.req_write_enable = 1'b0;
    #1;
    chk("t2_store_count", 64'(bus.outstanding_count), 64'd4);

    // Free of tag 2 races a pending load
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_tag   = 2'd2;
    bus.mem_rsp_data  = line;
    #1;
    chk("t3_ready_before", 64'(bus.req_ready), 64'd0);
    tick();
    bus.mem_rsp_valid = 1'b0;
    #1;
    chk("t3_wb_tid", 64'(bus.wb_tid), 64'h102);
    chk("t3_wb_data", bus.wb_data, 64'h05);
    chk("t3_ready_freecycle", 64'(bus.req_ready), 64'd0);
    tick();
    chk("t3_ready_after", 64'(bus.req_ready), 64'd1);
    chk("t3_reuse_tag", 64'(bus.mem_req_tag), 64'd2);
    tick();
    bus.req_valid = 1'b0;
    #1;
    chk("t3_count", 64'(bus.outstanding_count), 64'd4);

    rst = 1'b1;
    #1;
    chk("t3_rst_count", 64'(bus.outstanding_count), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Back-pressure on a 2-byte scatter with tid wrap
    set_load(10'h3FE, 8'hA6, 2'b01,
             (40'd3 << 5) | (40'd7 << 10) | (40'd31 << 25) | (40'd16 << 35));
    #1;
    chk("t4_tag", 64'(bus.mem_req_tag), 64'd0);
    tick();
    bus.req_valid = 1'b0;
    send_rsp(2'd0);
    chk("t4_wb0_tid", 64'(bus.wb_tid), 64'h3FF);
    chk("t4_wb0_data", bus.wb_data, 64'h0302);
    wb_step();
    bus.wb_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk($sformatf("t4_stall%0d_valid", s), 64'(bus.wb_valid), 64'd1);
      chk($sformatf("t4_stall%0d_tid", s), 64'(bus.wb_tid), 64'h000);
      chk($sformatf("t4_stall%0d_data", s), bus.wb_data, 64'h0706);
      wb_step();
    end
    bus.wb_ready = 1'b1;
    #1;
    chk("t4_wb1_tid", 64'(bus.wb_tid), 64'h000);
    wb_step();
    chk("t4_wb2_tid", 64'(bus.wb_tid), 64'h003);
    chk("t4_wb2_data", bus.wb_data, 64'h1F1E);
    wb_step();
    chk("t4_wb3_tid", 64'(bus.wb_tid), 64'h005);
    chk("t4_wb3_data", bus.wb_data, 64'h1110);
    wb_step();
    chk("t4_done_valid", 64'(bus.wb_valid), 64'd0);
    chk("t4_wb_total", 64'(n_wb), 64'd4);
    chk("t4_count", 64'(bus.outstanding_count), 64'd0);

    // Response for a tag nobody owns
    send_rsp(2'd1);
    chk("t5_err", 64'(bus.err_unexpected_rsp), 64'd1);
    chk("t5_no_wb", 64'(bus.wb_valid), 64'd0);
    chk("t5_rsp_ready", 64'(bus.mem_rsp_ready), 64'd1);
    tick();
    tick();
    chk("t5_err_sticky", 64'(bus.err_unexpected_rsp), 64'd1);

    // Reset in the middle of a four-thread scatter
    set_load(10'h010, 8'h0F, 2'b00, 40'd0);
    #1;
    chk("t6_tag", 64'(bus.mem_req_tag), 64'd0);
    tick();
    bus.req_valid = 1'b0;
    send_rsp(2'd0);
    chk("t6_wb0_tid", 64'(bus.wb_tid), 64'h010);
    tick();
    chk("t6_wb1_valid", 64'(bus.wb_valid), 64'd1);
    chk("t6_wb1_tid", 64'(bus.wb_tid), 64'h011);
    rst = 1'b1;
    #1;
    chk("t6_rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("t6_rst_count", 64'(bus.outstanding_count), 64'd0);
    chk("t6_rst_err", 64'(bus.err_unexpected_rsp), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_idle_wb_valid", 64'(bus.wb_valid), 64'd0);
    set_load(10'h020, 8'h01, 2'b11, 40'd0);
    #1;
    chk("t6_next_tag", 64'(bus.mem_req_tag), 64'd0);
    tick();
    bus.req_valid = 1'b0;
    send_rsp(2'd0);
    chk("t6_8b_data", bus.wb_data, 64'h0706050403020100);
    tick();
    chk("t6_final_count", 64'(bus.outstanding_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
